ram_bit_serializer: RTL and testbench

- Bit-serial read sequencer that drives the 1-bit port of the asymmetric block RAM (1-bit x 16384 side, byte-wide bus side).
- The bus writes pattern bytes into the RAM's 8-bit port. This block streams BIT_COUNT bits from START_ADDR onward as a serial output, optionally repeated with an idle gap.
- Feeds serial output drivers (SPI-like / pattern outputs).

---
 rtl/ram_bit_serializer.sv | 140 ++++++++++++++
 tb/tb_ram_bit_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bit_serializer.sv
// Bit-serial read sequencer for the 1-bit port of the asymmetric pattern RAM.
// Streams BIT_COUNT bits from START_ADDR, optionally repeated with idle gaps.
module ram_bit_serializer #(
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 16,
  parameter int REP_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [CNT_WIDTH-1:0]  BIT_COUNT,
  input  logic [REP_WIDTH-1:0]  REPEAT,
  input  logic [CNT_WIDTH-1:0]  WAIT,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_EN,
  input  logic                  RAM_DO,
  output logic                  SDO,
  output logic                  SDO_VALID,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    GAP,
    DRAIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cfg_addr;
  logic [CNT_WIDTH-1:0]  cfg_count;
  logic [REP_WIDTH-1:0]  cfg_rep;
  logic [CNT_WIDTH-1:0]  cfg_wait;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [REP_WIDTH-1:0]  pass_cnt;
  logic [CNT_WIDTH-1:0]  gap_cnt;
  logic                  en_d1;

  // bit_cnt counts addresses issued in the current pass, including the one on RAM_ADDR now.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cfg_addr  <= '0;
      cfg_count <= '0;
      cfg_rep   <= '0;
      cfg_wait  <= '0;
      bit_cnt   <= '0;
      pass_cnt  <= '0;
      gap_cnt   <= '0;
      en_d1     <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_EN    <= 1'b0;
      SDO       <= 1'b0;
      SDO_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE      <= 1'b0;
      SDO       <= RAM_DO;
      en_d1     <= RAM_EN;
      SDO_VALID <= en_d1;

      if (state == IDLE) begin
        if (START) begin
          cfg_addr  <= START_ADDR;
          cfg_count <= BIT_COUNT;
          cfg_rep   <= (REPEAT == '0) ? REP_WIDTH'(1) : REPEAT;
          cfg_wait  <= WAIT;
          bit_cnt   <= CNT_WIDTH'(1);
          pass_cnt  <= REP_WIDTH'(1);
          gap_cnt   <= '0;
          if (BIT_COUNT != '0) begin
            RAM_ADDR <= START_ADDR;
            RAM_EN   <= 1'b1;
            BUSY     <= 1'b1;
            state    <= READ;
          end else begin
            DONE <= 1'b1;
          end
        end
      end else if (ABORT) begin
        // Flushing en_d1 as well guarantees no stale SDO_VALID after the abort.
        RAM_EN    <= 1'b0;
        en_d1     <= 1'b0;
        SDO_VALID <= 1'b0;
        BUSY      <= 1'b0;
        state     <= IDLE;
      end else begin
        case (state)
          READ: begin
            if (bit_cnt == cfg_count) begin
              if (pass_cnt != cfg_rep) begin
                pass_cnt <= pass_cnt + REP_WIDTH'(1);
                if (cfg_wait != '0) begin
                  RAM_EN  <= 1'b0;
                  gap_cnt <= CNT_WIDTH'(1);
                  state   <= GAP;
                end else begin
                  RAM_ADDR <= cfg_addr;
                  bit_cnt  <= CNT_WIDTH'(1);
                end
              end else begin
                RAM_EN <= 1'b0;
                state  <= DRAIN;
              end
            end else begin
              RAM_ADDR <= RAM_ADDR + ADDR_WIDTH'(1);
              bit_cnt  <= bit_cnt + CNT_WIDTH'(1);
            end
          end
          GAP: begin
            if (gap_cnt == cfg_wait) begin
              RAM_ADDR <= cfg_addr;
              RAM_EN   <= 1'b1;
              bit_cnt  <= CNT_WIDTH'(1);
              state    <= READ;
            end else begin
              gap_cnt <= gap_cnt + CNT_WIDTH'(1);
            end
          end
          DRAIN: begin
            // Once en_d1 is clear the last valid bit is on SDO this cycle.
            if (!en_d1) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_bit_serializer.sv
// Scoreboard bench for ram_bit_serializer with a behavioural 1-bit RAM port.
module tb_ram_bit_serializer;

  localparam int AW    = 14;
  localparam int CW    = 16;
  localparam int RW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [AW-1:0] START_ADDR = '0;
  logic [CW-1:0] BIT_COUNT = '0;
  logic [RW-1:0] REPEAT = '0;
  logic [CW-1:0] WAIT = '0;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_EN;
  logic          RAM_DO = 1'b0;
  logic          SDO;
  logic          SDO_VALID;
  logic          BUSY;
  logic          DONE;

  typedef struct {
    int cyc;
    bit val;
  } exp_t;

  bit   mem [DEPTH];
  exp_t exp_q[$];
  int   exp_done_cyc = -1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   abort_on_start = 1'b0;

  ram_bit_serializer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .START_ADDR(START_ADDR), .BIT_COUNT(BIT_COUNT), .REPEAT(REPEAT), .WAIT(WAIT),
    .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN), .RAM_DO(RAM_DO),
    .SDO(SDO), .SDO_VALID(SDO_VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM bit port; data appears the cycle after the address.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RAM_EN === 1'b1) RAM_DO <= mem[RAM_ADDR];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (SDO_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("valid_cyc", cyc, e.cyc);
        checkOutput("sdo", {31'd0, SDO}, {31'd0, e.val});
      end
    end
    if (DONE === 1'b1) begin
      if (exp_done_cyc < 0) begin
        checkOutput("extra_done", 1, 0);
      end else begin
        checkOutput("done_cyc", cyc, exp_done_cyc);
        checkOutput("busy_at_done", {31'd0, BUSY}, 0);
        exp_done_cyc = -1;
      end
    end
  end

  task automatic applyStimulus(input int addr, input int count, input int rep, input int wt,
                               input int keep, input bit expect_done);
    int   passes;
    int   n;
    exp_t e;
    @(negedge CLK);
    START_ADDR = AW'(addr);
    BIT_COUNT  = CW'(count);
    REPEAT     = RW'(rep);
    WAIT       = CW'(wt);
    START      = 1'b1;
    ABORT      = abort_on_start;
    passes     = (rep == 0) ? 1 : rep;
    n          = 0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < count; i++) begin
        if (keep < 0 || n < keep) begin
          e.cyc = cyc + 3 + p * (count + wt) + i;
          e.val = mem[(addr + i) % DEPTH];
          exp_q.push_back(e);
        end
        n++;
      end
    end
    if (!expect_done)     exp_done_cyc = -1;
    else if (count == 0)  exp_done_cyc = cyc + 1;
    else                  exp_done_cyc = cyc + 3 + passes * count + (passes - 1) * wt;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic finishRun(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_done_cyc < 0) break;
      @(negedge CLK);
    end
    checkOutput("run_complete", {31'd0, (exp_q.size() == 0 && exp_done_cyc < 0)}, 1);
    exp_q.delete();
    exp_done_cyc = -1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, {18'd0, RAM_ADDR}, 0);
    checkOutput({tag, "_en"}, {31'd0, RAM_EN}, 0);
    checkOutput({tag, "_sdo"}, {31'd0, SDO}, 0);
    checkOutput({tag, "_valid"}, {31'd0, SDO_VALID}, 0);
    checkOutput({tag, "_busy"}, {31'd0, BUSY}, 0);
    checkOutput({tag, "_done"}, {31'd0, DONE}, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual timeout required completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : main
    logic [7:0] b;
    for (int a = 0; a < DEPTH / 8; a++) begin
      b = (a == 0) ? 8'hA5 : 8'($urandom);
      for (int k = 0; k < 8; k++) mem[a * 8 + k] = b[k];
    end

    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkAllZero("reset");
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] basic pass");
    applyStimulus(0, 8, 1, 0, -1, 1);
    checkOutput("busy_start", {31'd0, BUSY}, 1);
    checkOutput("ram_en_start", {31'd0, RAM_EN}, 1);
    finishRun(100);

    $display("[TB] address wrap");
    applyStimulus(16382, 4, 1, 0, -1, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_addr", {18'd0, RAM_ADDR}, (16382 + i) % DEPTH);
      checkOutput("wrap_en", {31'd0, RAM_EN}, 1);
      @(negedge CLK);
    end
    finishRun(100);

    $display("[TB] repeat with gap, without gap, repeat zero");
    applyStimulus(40, 3, 2, 5, -1, 1);
    finishRun(100);
    applyStimulus(40, 3, 2, 0, -1, 1);
    finishRun(100);
    applyStimulus(100, 5, 0, 3, -1, 1);
    finishRun(100);

    $display("[TB] empty sequence");
    applyStimulus(0, 0, 1, 0, -1, 1);
    checkOutput("empty_busy", {31'd0, BUSY}, 0);
    checkOutput("empty_en", {31'd0, RAM_EN}, 0);
    finishRun(100);

    $display("[TB] start while busy");
    applyStimulus(200, 8, 1, 0, -1, 1);
    @(negedge CLK);
    START_ADDR = AW'(5);
    BIT_COUNT  = CW'(3);
    REPEAT     = RW'(4);
    WAIT       = CW'(2);
    START      = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    finishRun(100);

    $display("[TB] abort mid pass");
    applyStimulus(300, 16, 1, 0, 2, 0);
    repeat (3) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checkOutput("abort_en", {31'd0, RAM_EN}, 0);
    checkOutput("abort_valid", {31'd0, SDO_VALID}, 0);
    checkOutput("abort_busy", {31'd0, BUSY}, 0);
    finishRun(100);

    $display("[TB] start and abort together in idle");
    abort_on_start = 1'b1;
    applyStimulus(77, 10, 1, 0, -1, 1);
    abort_on_start = 1'b0;
    finishRun(100);

    $display("[TB] reset during gap");
    applyStimulus(500, 3, 3, 5, 3, 0);
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    finishRun(100);
    applyStimulus(500, 3, 3, 5, -1, 1);
    finishRun(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
